// File: rtl/sync_ptr_gray.sv
// Gray pointer synchroniser for the async FIFO destination domain.
// Ports: i_clk/i_rst (sync, active-high), i_ptr_gray in, i_lptr_bin local,
//   i_err_clr; o_ptr_sync, o_ptr_bin, o_ptr_upd, o_valid, o_level, o_err.
module sync_ptr_gray #(
  parameter int ADDRSIZE    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [ADDRSIZE:0]   i_ptr_gray,
  input  logic [ADDRSIZE:0]   i_lptr_bin,
  input  logic                i_err_clr,
  output logic [ADDRSIZE:0]   o_ptr_sync,
  output logic [ADDRSIZE:0]   o_ptr_bin,
  output logic                o_ptr_upd,
  output logic                o_valid,
  output logic [ADDRSIZE:0]   o_level,
  output logic                o_err
);

  localparam int W    = ADDRSIZE + 1;
  localparam int VMAX = SYNC_STAGES + 1;
  localparam int CW   = $clog2(VMAX + 1);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
    $error("sync_ptr_gray: SYNC_STAGES must be 2..4");
  end

  logic [W-1:0]  stage [SYNC_STAGES];
  logic [W-1:0]  sync_prev;
  logic [W-1:0]  bin_next;
  logic [CW-1:0] vcnt;
  logic          step_bad;

  assign o_ptr_sync = stage[SYNC_STAGES-1];

  always_comb begin
    bin_next        = '0;
    bin_next[W-1]   = o_ptr_sync[W-1];
    for (int i = W - 2; i >= 0; i--) begin
      bin_next[i] = bin_next[i+1] ^ o_ptr_sync[i];
    end
  end

  // More than one Gray bit moving between samples means a torn pointer.
  assign step_bad = $countones(o_ptr_sync ^ sync_prev) > 1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        stage[k] <= '0;
      end
    end else begin
      stage[0] <= i_ptr_gray;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        stage[k] <= stage[k-1];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_prev <= '0;
      o_ptr_bin <= '0;
      o_ptr_upd <= 1'b0;
      o_level   <= '0;
    end else begin
      sync_prev <= o_ptr_sync;
      o_ptr_bin <= bin_next;
      o_ptr_upd <= o_valid && (bin_next != o_ptr_bin);
      o_level   <= i_lptr_bin - o_ptr_bin;
    end
  end

  // Valid follows once every pipeline stage holds post-reset data.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vcnt    <= '0;
      o_valid <= 1'b0;
    end else begin
      if (vcnt != CW'(VMAX)) begin
        vcnt <= vcnt + 1'b1;
      end
      o_valid <= (vcnt >= CW'(VMAX - 1));
    end
  end

  // Set wins over clear on the same edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_err <= 1'b0;
    end else if (o_valid && step_bad) begin
      o_err <= 1'b1;
    end else if (i_err_clr) begin
      o_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sync_ptr_gray.sv
// Bench for sync_ptr_gray: default instance plus a SYNC_STAGES=3 instance.
// Table of held pointers for level/binary plus directed multi-cycle cases.
module tb_sync_ptr_gray;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] ptr, lptr;
  logic       clr;
  logic [4:0] sync_o, bin_o, lvl_o;
  logic       upd_o, val_o, err_o;

  logic [4:0] ptr3, lptr3;
  logic       clr3;
  logic [4:0] sync3, bin3, lvl3;
  logic       upd3, val3, err3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sync_ptr_gray #(.ADDRSIZE(4), .SYNC_STAGES(2)) dut (
    .i_clk(clk), .i_rst(rst), .i_ptr_gray(ptr), .i_lptr_bin(lptr),
    .i_err_clr(clr), .o_ptr_sync(sync_o), .o_ptr_bin(bin_o),
    .o_ptr_upd(upd_o), .o_valid(val_o), .o_level(lvl_o), .o_err(err_o)
  );

  sync_ptr_gray #(.ADDRSIZE(4), .SYNC_STAGES(3)) dut3 (
    .i_clk(clk), .i_rst(rst), .i_ptr_gray(ptr3), .i_lptr_bin(lptr3),
    .i_err_clr(clr3), .o_ptr_sync(sync3), .o_ptr_bin(bin3),
    .o_ptr_upd(upd3), .o_valid(val3), .o_level(lvl3), .o_err(err3)
  );

  typedef struct {
    logic [4:0] gray;
    logic [4:0] lptr;
    logic [4:0] bin;
    logic [4:0] lvl;
  } vec_t;

  vec_t tbl [7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [4:0] g(input int n);
    logic [4:0] v;
    v = 5'(n);
    return v ^ (v >> 1);
  endfunction

  initial begin
    tbl[0] = '{5'b00010, 5'd18, 5'd3,  5'd15};
    tbl[1] = '{5'b10001, 5'd1,  5'd30, 5'd3};
    tbl[2] = '{5'b11000, 5'd16, 5'd16, 5'd0};
    tbl[3] = '{5'b00000, 5'd16, 5'd0,  5'd16};
    tbl[4] = '{5'b00100, 5'd10, 5'd7,  5'd3};
    tbl[5] = '{5'b10000, 5'd31, 5'd31, 5'd0};
    tbl[6] = '{5'b01111, 5'd5,  5'd10, 5'd27};

    rst = 1'b1; ptr = '0; lptr = '0; clr = 1'b0;
    ptr3 = 5'b00110; lptr3 = '0; clr3 = 1'b0;
    tick();
    tick();
    chk("rst_sync", sync_o, 0);
    chk("rst_bin", bin_o, 0);
    chk("rst_valid", val_o, 0);
    chk("rst_upd", upd_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_level", lvl_o, 0);
    chk("rst_valid3", val3, 0);
    chk("rst_bin3", bin3, 0);

    // Release: default instance valid at edge 3, SS=3 instance at edge 4.
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("valid_e%0d", k), val_o, (k >= 3) ? 1 : 0);
      chk($sformatf("valid3_e%0d", k), val3, (k >= 4) ? 1 : 0);
      chk($sformatf("upd3_e%0d", k), upd3, 0);
    end
    chk("bin3_e4", bin3, 4);
    chk("sync3_hold", sync3, 5'b00110);

    // Full Gray sweep including wrap back to 0.
    for (int n = 1; n <= 32; n++) begin
      ptr = g(n % 32);
      for (int k = 1; k <= 3; k++) begin
        tick();
        if (k < 3) begin
          chk($sformatf("sweep%0d_hold", n), bin_o, (n - 1) % 32);
          chk($sformatf("sweep%0d_noupd", n), upd_o, 0);
        end else begin
          chk($sformatf("sweep%0d_bin", n), bin_o, n % 32);
          chk($sformatf("sweep%0d_upd", n), upd_o, 1);
        end
      end
    end
    tick();
    chk("sweep_upd_drop", upd_o, 0);
    chk("sweep_err", err_o, 0);

    // Illegal jump 00001 -> 00111.
    ptr = 5'b00001;
    repeat (4) tick();
    chk("jump_pre_bin", bin_o, 1);
    chk("jump_pre_err", err_o, 0);
    ptr = 5'b00111;
    tick();
    tick();
    chk("jump_e2_err", err_o, 0);
    tick();
    chk("jump_bin", bin_o, 5);
    chk("jump_err", err_o, 1);
    chk("jump_upd", upd_o, 1);
    repeat (3) tick();
    chk("jump_sticky", err_o, 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_err", err_o, 0);

    // Illegal jump whose error edge meets a clear pulse.
    ptr = 5'b00000;
    tick();
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("setclr_bin", bin_o, 0);
    chk("setclr_err", err_o, 1);

    for (int i = 0; i < 7; i++) begin
      ptr  = tbl[i].gray;
      lptr = tbl[i].lptr;
      repeat (4) tick();
      chk($sformatf("tbl%0d_bin", i), bin_o, tbl[i].bin);
      chk($sformatf("tbl%0d_level", i), lvl_o, tbl[i].lvl);
    end

    lptr = 5'd12;
    tick();
    chk("level_lat", lvl_o, 2);

    // Reset in the middle of a sweep.
    ptr = g(11);
    repeat (3) tick();
    chk("mid_bin", bin_o, 11);
    ptr = g(12);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_sync", sync_o, 0);
    chk("mrst_bin", bin_o, 0);
    chk("mrst_valid", val_o, 0);
    chk("mrst_upd", upd_o, 0);
    chk("mrst_err", err_o, 0);
    chk("mrst_level", lvl_o, 0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk($sformatf("mrst_valid_e%0d", k), val_o, (k >= 3) ? 1 : 0);
      chk($sformatf("mrst_upd_e%0d", k), upd_o, 0);
    end
    chk("mrst_bin_e3", bin_o, 12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
